instr_fetch_seq: RTL and testbench
==================================

# instr_fetch_seq

Instruction fetch sequencer that sits in front of the opcode decoder. It owns the PC, reads the instruction memory, and latches each word into an instruction register. It presents `opcode` and `literal` to the decoder and datapath for exactly one execute cycle per instruction. It also resolves conditional jumps from the datapath status flags.

## Interface
- `PC_W`, 8, PC and instruction-memory address width
- `OP_W`, 7, opcode width
- `LIT_W`, 8, literal width; instruction word is `{opcode, literal}`, `OP_W+LIT_W` bits
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `hold`  in  1  freeze request; FSM and all registers keep their value while high
- `status`  in  4  registered flags from the last executed instruction: [0]=Z, [1]=N, [2]=C, [3]=V
- `im_addr`  out  PC_W  instruction-memory address
- `im_re`  out  1  instruction-memory read enable
- `im_rdata`  in  OP_W+LIT_W  read data, valid exactly 1 cycle after `im_re`
- `opcode`  out  OP_W  to decoder; `NOP_OP` unless executing
- `literal`  out  LIT_W  K operand to datapath
- `instr_valid`  out  1  high in the execute cycle
- `pc`  out  PC_W  address of the current instruction
- `jump_taken`  out  1  one-cycle pulse when a jump redirects the PC
- `halted`  out  1  high in HALT

## Operation
- FSM states are FETCH, WAIT, EXEC and HALT. The reset state is FETCH.
- FETCH: `im_addr=pc`, `im_re=1`. Go to WAIT.
- WAIT: on the clock edge, latch `im_rdata` into IR. Go to EXEC.
- EXEC: `instr_valid=1`, `opcode=IR[OP_W+LIT_W-1:LIT_W]`, `literal=IR[LIT_W-1:0]`. On the edge:
  - Opcode is HALT_OP (7'b1111111): go to HALT, PC unchanged.
  - Opcode is a jump and its condition is true: `pc<=literal`, `jump_taken=1`.
  - Otherwise `pc<=pc+1` (mod 2^PC_W; 255 wraps to 0). Go to FETCH.
- Jump opcodes and conditions:
  - JMP 7'b1010000: always
  - JEQ 7'b1010001: Z
  - JNE 7'b1010010: !Z
  - JGT 7'b1010011: !N&!Z
  - JLT 7'b1010100: N
  - JGE 7'b1010101: !N
  - JLE 7'b1010110: N|Z
  - JCR 7'b1010111: C
  - JOV 7'b1011000: V
- Jump opcodes are not decoded by the downstream decoder, so it treats them as NOP.
- `status` is sampled combinationally in EXEC. It reflects the previous instruction, because that instruction's flags were registered at its EXEC edge.
- Outside EXEC, `opcode=NOP_OP` (7'b1111110) and `literal=0`. The downstream decoder decodes opcode 0 as MOV A,B, so a stray 0 would corrupt A.
- HALT: `halted=1` and `opcode=NOP_OP`. HALT is left only by reset.
- `hold=1` in any state:
  - No state or register change.
  - `instr_valid=0`, `opcode=NOP_OP`, `im_re=0`, `jump_taken=0`.
  - If held in WAIT, the memory data is re-requested: the FSM returns to FETCH when hold drops. A WAIT under hold never latches stale data.

## Timing
- Reset values: `pc=0`, state FETCH, IR=0, `im_addr=0`, `opcode=NOP_OP`, `literal=0`, `instr_valid=0`, `jump_taken=0`, `halted=0`. `im_re=1` in the first cycle after reset release.
- Fixed throughput is 3 cycles per instruction without hold. FETCH→EXEC latency is 2 cycles.
- `jump_taken` is asserted in the EXEC cycle, combinationally; it is not registered. The PC changes at the end of that cycle.
- Reset mid-instruction (any state) returns to FETCH at pc 0 on the next edge. No `instr_valid` pulse is emitted for the aborted instruction.
- `hold` and reset together: reset wins.
- `hold` asserted in EXEC delays the execute pulse. `instr_valid` goes high in the first EXEC cycle with `hold=0`, using the status at that time.

## Structure
- Shared header/package `isa_defs`: OP_W, LIT_W, NOP_OP, HALT_OP, all jump opcode constants, and status bit indices Z/N/C/V. The decoder uses the same constants.
- FSM state encoding is local to this block.
- One sub-module: `jump_cond`, combinational. Inputs are opcode and status; outputs are `is_jump` and `take`. It is unit-testable on its own.

## Test plan
- Reset, then a linear program with mem[0]=MOV A,K 0x05 and mem[1]=ADD A,B:
  - `instr_valid` pulses at cycles 3 and 6.
  - `pc` is 0, then 1, then 2.
  - Opcode is NOP_OP between pulses.
- JEQ taken and not taken, with mem[2]=JEQ 0x10:
  - `status=4'b0001`: `jump_taken=1` in EXEC, next `im_addr=0x10`.
  - `status=0`: `jump_taken=0`, next `im_addr=3`.
- Condition sweep: JGT, JLE, JCR and JOV each against all 16 status values; taken exactly per the table.
- PC wrap: mem[255]=ADD A,B leads to the next FETCH at `im_addr=0`.
- Hold:
  - `hold=1` for 4 cycles in WAIT: no latch; FETCH is re-issued with the same `im_addr`; one `instr_valid` pulse total.
  - Hold in EXEC: the pulse is delayed, not duplicated.
- Halt and reset:
  - mem[4]=HALT_OP: `halted=1` forever, `im_re=0`, `pc=4`.
  - `rst_n=0` for 1 cycle during HALT or WAIT: `pc=0`, `halted=0`, FETCH on the next cycle.

Source files
------------

// File: rtl/isa_defs_pkg.sv
// ISA constants shared by the fetch sequencer and the opcode decoder:
// field widths, special opcodes, jump opcodes and status flag positions.
package isa_defs;

  localparam int OP_W    = 7;
  localparam int LIT_W   = 8;
  localparam int INSTR_W = OP_W + LIT_W;

  localparam logic [OP_W-1:0] NOP_OP  = 7'b1111110;
  localparam logic [OP_W-1:0] HALT_OP = 7'b1111111;

  localparam logic [OP_W-1:0] JMP_OP = 7'b1010000;
  localparam logic [OP_W-1:0] JEQ_OP = 7'b1010001;
  localparam logic [OP_W-1:0] JNE_OP = 7'b1010010;
  localparam logic [OP_W-1:0] JGT_OP = 7'b1010011;
  localparam logic [OP_W-1:0] JLT_OP = 7'b1010100;
  localparam logic [OP_W-1:0] JGE_OP = 7'b1010101;
  localparam logic [OP_W-1:0] JLE_OP = 7'b1010110;
  localparam logic [OP_W-1:0] JCR_OP = 7'b1010111;
  localparam logic [OP_W-1:0] JOV_OP = 7'b1011000;

  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int C_BIT = 2;
  localparam int V_BIT = 3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [LIT_W-1:0] lit;
  } instr_t;

endpackage

// File: rtl/instr_fetch_seq_jump_cond.sv
// Combinational jump resolver: flags whether an opcode is a jump and whether
// its condition holds for the current status flags.
module jump_cond
  import isa_defs::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic [3:0]      status,
  output logic            is_jump,
  output logic            take
);

  logic w_z, w_n, w_c, w_v;

  assign w_z = status[Z_BIT];
  assign w_n = status[N_BIT];
  assign w_c = status[C_BIT];
  assign w_v = status[V_BIT];

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    is_jump = 1'b1;
    take    = 1'b0;
    case (opcode)
      JMP_OP:  take = 1'b1;
      JEQ_OP:  take = w_z;
      JNE_OP:  take = !w_z;
      JGT_OP:  take = !w_n && !w_z;
      JLT_OP:  take = w_n;
      JGE_OP:  take = !w_n;
      JLE_OP:  take = w_n || w_z;
      JCR_OP:  take = w_c;
      JOV_OP:  take = w_v;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: FETCH -> WAIT -> EXEC per instruction, owns the
// PC, latches memory words into IR and resolves conditional jumps.
module instr_fetch_seq
  import isa_defs::*;
#(
  parameter int PC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic [3:0]         status,
  output logic [PC_W-1:0]    im_addr,
  output logic               im_re,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic [OP_W-1:0]    opcode,
  output logic [LIT_W-1:0]   literal,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               jump_taken,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  instr_t          r_ir;
  logic            r_refetch;
  logic            w_ir_load;
  logic            w_exec;
  logic            w_is_jump;
  logic            w_take;

  assign w_exec = (r_state == S_EXEC) && !hold;

  jump_cond u_jump_cond (
    .opcode  (r_ir.op),
    .status  (status),
    .is_jump (w_is_jump),
    .take    (w_take)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_ir_load    = 1'b0;
    case (r_state)
      S_FETCH: w_next_state = S_WAIT;
      S_WAIT: begin
        // Data requested before a hold is stale by now; ask for it again.
        if (r_refetch) begin
          w_next_state = S_FETCH;
        end else begin
          w_ir_load    = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_ir.op == HALT_OP) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_FETCH;
          if (w_is_jump && w_take) w_next_pc = PC_W'(r_ir.lit);
          else                     w_next_pc = r_pc + PC_W'(1'b1);
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and checked before hold.
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_refetch <= 1'b0;
    end else if (hold) begin
      if (r_state == S_WAIT) r_refetch <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_refetch <= 1'b0;
      if (w_ir_load) r_ir <= im_rdata;
    end
  end

  // A stray opcode 0 decodes as MOV A,B downstream, so idle cycles drive NOP.
  assign opcode      = w_exec ? r_ir.op  : NOP_OP;
  assign literal     = w_exec ? r_ir.lit : '0;
  assign instr_valid = w_exec;
  assign jump_taken  = w_exec && w_is_jump && w_take;
  assign im_addr     = r_pc;
  assign im_re       = (r_state == S_FETCH) && !hold;
  assign pc          = r_pc;
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus a random
// program run checked against an instruction-level reference model.
module tb_instr_fetch_seq;

  localparam logic [6:0] NOP  = 7'h7E;
  localparam logic [6:0] HALT = 7'h7F;
  localparam logic [6:0] MOVK = 7'h04;
  localparam logic [6:0] ADD  = 7'h10;
  localparam logic [6:0] JMP  = 7'h50;
  localparam logic [6:0] JEQ  = 7'h51;
  localparam logic [6:0] JGT  = 7'h53;
  localparam logic [6:0] JLE  = 7'h56;
  localparam logic [6:0] JCR  = 7'h57;
  localparam logic [6:0] JOV  = 7'h58;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hold = 1'b0;
  logic [3:0]  status = 4'h0;
  logic [7:0]  im_addr;
  logic        im_re;
  logic [14:0] im_rdata;
  logic [6:0]  opcode;
  logic [7:0]  literal;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        jump_taken;
  logic        halted;

  logic [14:0] mem [256];
  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_seq #(.PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .status(status),
    .im_addr(im_addr), .im_re(im_re), .im_rdata(im_rdata),
    .opcode(opcode), .literal(literal), .instr_valid(instr_valid),
    .pc(pc), .jump_taken(jump_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory returns data one cycle after a read; otherwise garbage.
  always @(posedge clk) begin
    if (im_re) im_rdata <= mem[im_addr];
    else       im_rdata <= 15'($urandom);
  end

  function automatic bit ref_take(input logic [6:0] op, input logic [3:0] st);
    bit z, n, c, v;
    z = st[0]; n = st[1]; c = st[2]; v = st[3];
    case (op)
      7'h50: return 1'b1;
      7'h51: return z;
      7'h52: return !z;
      7'h53: return !n && !z;
      7'h54: return n;
      7'h55: return !n;
      7'h56: return n || z;
      7'h57: return c;
      7'h58: return v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit h, input logic [3:0] st);
    @(posedge clk); #1;
    hold = h; status = st;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 4'h0);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = {ADD, 8'h00};
  endtask

  task automatic test_reset();
    hold = 1'b1; rst_n = 1'b0;
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    n_checks++; if (pc !== 8'h00) begin n_errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    n_checks++; if (im_addr !== 8'h00) begin n_errors++; $display("FAIL reset_im_addr: got %h want 00", im_addr); end
    n_checks++; if (opcode !== NOP) begin n_errors++; $display("FAIL reset_opcode: got %h want %h", opcode, NOP); end
    n_checks++; if (literal !== 8'h00) begin n_errors++; $display("FAIL reset_literal: got %h want 00", literal); end
    n_checks++; if ({instr_valid, jump_taken, halted} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {instr_valid, jump_taken, halted}); end
    rst_n = 1'b1; hold = 1'b0; #1;
    n_checks++; if (im_re !== 1'b1) begin n_errors++; $display("FAIL reset_im_re: got %b want 1", im_re); end
  endtask

  task automatic test_linear();
    bit         exp_v;
    logic [7:0] exp_pc;
    fill_mem();
    mem[0] = {MOVK, 8'h05};
    mem[1] = {ADD, 8'h00};
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) step(1'b0, 4'h0);
      exp_v  = (c % 3 == 0);
      exp_pc = 8'((c - 1) / 3);
      n_checks++; if (instr_valid !== exp_v) begin n_errors++; $display("FAIL linear_valid c%0d: got %b want %b", c, instr_valid, exp_v); end
      n_checks++; if (pc !== exp_pc) begin n_errors++; $display("FAIL linear_pc c%0d: got %h want %h", c, pc, exp_pc); end
      n_checks++; if (opcode !== (exp_v ? mem[exp_pc][14:8] : NOP)) begin n_errors++; $display("FAIL linear_opcode c%0d: got %h", c, opcode); end
      n_checks++; if (literal !== (exp_v ? mem[exp_pc][7:0] : 8'h00)) begin n_errors++; $display("FAIL linear_literal c%0d: got %h", c, literal); end
    end
  endtask

  task automatic test_jeq();
    logic [3:0] st;
    for (int t = 0; t < 2; t++) begin
      st = (t == 0) ? 4'b0001 : 4'b0000;
      fill_mem();
      mem[2] = {JEQ, 8'h10};
      do_reset();
      for (int c = 2; c <= 9; c++) step(1'b0, st);
      n_checks++; if ({instr_valid, pc} !== {1'b1, 8'h02}) begin n_errors++; $display("FAIL jeq_exec t%0d: got v=%b pc=%h want v=1 pc=02", t, instr_valid, pc); end
      n_checks++; if (jump_taken !== (t == 0)) begin n_errors++; $display("FAIL jeq_taken t%0d: got %b want %b", t, jump_taken, t == 0); end
      step(1'b0, st);
      n_checks++; if ({im_re, im_addr} !== {1'b1, (t == 0) ? 8'h10 : 8'h03}) begin n_errors++; $display("FAIL jeq_next_addr t%0d: got re=%b addr=%h", t, im_re, im_addr); end
    end
  endtask

  task automatic test_cond_sweep();
    logic [6:0] ops [4];
    logic [7:0] lit;
    bit         exp;
    ops[0] = JGT; ops[1] = JLE; ops[2] = JCR; ops[3] = JOV;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 16; s++) begin
        fill_mem();
        lit = 8'($urandom_range(2, 255));
        mem[0] = {ops[k], lit};
        exp = ref_take(ops[k], 4'(s));
        do_reset();
        step(1'b0, 4'(s));
        step(1'b0, 4'(s));
        n_checks++; if ({instr_valid, jump_taken} !== {1'b1, exp}) begin n_errors++; $display("FAIL sweep_taken op%h st%h: got v=%b t=%b want t=%b", ops[k], s, instr_valid, jump_taken, exp); end
        step(1'b0, 4'(s));
        n_checks++; if (im_addr !== (exp ? lit : 8'h01)) begin n_errors++; $display("FAIL sweep_addr op%h st%h: got %h want %h", ops[k], s, im_addr, exp ? lit : 8'h01); end
      end
    end
  endtask

  task automatic test_wrap();
    fill_mem();
    mem[0] = {JMP, 8'hFF};
    mem[255] = {ADD, 8'h33};
    do_reset();
    step(1'b0, 4'h0); step(1'b0, 4'h0);
    n_checks++; if (jump_taken !== 1'b1) begin n_errors++; $display("FAIL wrap_jmp: got %b want 1", jump_taken); end
    step(1'b0, 4'h0);
    n_checks++; if ({im_re, im_addr} !== {1'b1, 8'hFF}) begin n_errors++; $display("FAIL wrap_fetch255: got re=%b addr=%h", im_re, im_addr); end
    step(1'b0, 4'h0); step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, pc, opcode} !== {1'b1, 8'hFF, ADD}) begin n_errors++; $display("FAIL wrap_exec255: got v=%b pc=%h op=%h", instr_valid, pc, opcode); end
    step(1'b0, 4'h0);
    n_checks++; if ({im_re, im_addr} !== {1'b1, 8'h00}) begin n_errors++; $display("FAIL wrap_fetch0: got re=%b addr=%h want addr=00", im_re, im_addr); end
  endtask

  task automatic test_hold_wait();
    int pulses = 0;
    bit refetched = 1'b0;
    fill_mem();
    mem[0] = {MOVK, 8'h5A};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h0);
      n_checks++; if ({im_re, instr_valid} !== 2'b00) begin n_errors++; $display("FAIL holdw_idle i%0d: got re=%b v=%b want 00", i, im_re, instr_valid); end
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'h0);
      if (im_re && im_addr == 8'h00) refetched = 1'b1;
      if (instr_valid) begin
        pulses++;
        n_checks++; if ({pc, opcode, literal} !== {8'h00, MOVK, 8'h5A}) begin n_errors++; $display("FAIL holdw_data: got pc=%h op=%h lit=%h want 00/%h/5a", pc, opcode, literal, MOVK); end
      end
    end
    n_checks++; if (!refetched) begin n_errors++; $display("FAIL holdw_refetch: got none want im_re at addr 00"); end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL holdw_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_hold_exec();
    fill_mem();
    mem[0] = {JEQ, 8'h10};
    do_reset();
    step(1'b0, 4'h1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'h1);
      n_checks++; if ({instr_valid, jump_taken, opcode} !== {2'b00, NOP}) begin n_errors++; $display("FAIL holde_held i%0d: got v=%b t=%b op=%h", i, instr_valid, jump_taken, opcode); end
    end
    step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, jump_taken, opcode} !== {2'b10, JEQ}) begin n_errors++; $display("FAIL holde_release: got v=%b t=%b op=%h want v=1 t=0", instr_valid, jump_taken, opcode); end
    step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, im_re, im_addr} !== {2'b01, 8'h01}) begin n_errors++; $display("FAIL holde_after: got v=%b re=%b addr=%h", instr_valid, im_re, im_addr); end
    step(1'b0, 4'h0);
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL holde_dup: got %b want 0", instr_valid); end
    step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, pc} !== {1'b1, 8'h01}) begin n_errors++; $display("FAIL holde_next: got v=%b pc=%h", instr_valid, pc); end
  endtask

  task automatic test_halt_reset();
    fill_mem();
    mem[4] = {HALT, 8'h00};
    do_reset();
    for (int c = 2; c <= 15; c++) step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, pc, opcode} !== {1'b1, 8'h04, HALT}) begin n_errors++; $display("FAIL halt_exec: got v=%b pc=%h op=%h", instr_valid, pc, opcode); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'(i));
      n_checks++; if ({halted, im_re, instr_valid, pc, opcode} !== {3'b100, 8'h04, NOP}) begin n_errors++; $display("FAIL halt_stay i%0d: got h=%b re=%b v=%b pc=%h op=%h", i, halted, im_re, instr_valid, pc, opcode); end
    end
    rst_n = 1'b0;
    step(1'b1, 4'h0);
    n_checks++; if ({halted, instr_valid, pc} !== {2'b00, 8'h00}) begin n_errors++; $display("FAIL halt_reset: got h=%b v=%b pc=%h", halted, instr_valid, pc); end
    rst_n = 1'b1; hold = 1'b0; #1;
    n_checks++; if ({im_re, im_addr} !== {1'b1, 8'h00}) begin n_errors++; $display("FAIL halt_refetch: got re=%b addr=%h", im_re, im_addr); end
    // Reset while waiting on the second instruction's data.
    do_reset();
    for (int c = 2; c <= 5; c++) step(1'b0, 4'h0);
    rst_n = 1'b0;
    step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, pc} !== {1'b0, 8'h00}) begin n_errors++; $display("FAIL wait_reset: got v=%b pc=%h", instr_valid, pc); end
    rst_n = 1'b1; #1;
    n_checks++; if ({im_re, im_addr} !== {1'b1, 8'h00}) begin n_errors++; $display("FAIL wait_refetch: got re=%b addr=%h", im_re, im_addr); end
    step(1'b0, 4'h0); step(1'b0, 4'h0);
    n_checks++; if ({instr_valid, pc} !== {1'b1, 8'h00}) begin n_errors++; $display("FAIL wait_exec0: got v=%b pc=%h", instr_valid, pc); end
  endtask

  task automatic test_random_program();
    logic [6:0] jops [9];
    logic [7:0] model_pc = 8'h00;
    logic [3:0] st;
    bit         h, held = 1'b0, exp_t;
    int         last = 0;
    for (int j = 0; j < 9; j++) jops[j] = 7'(7'h50 + j);
    for (int i = 0; i < 256; i++)
      mem[i] = {($urandom_range(0, 1) == 1) ? jops[$urandom_range(0, 8)] : 7'($urandom_range(0, 7'h4F)), 8'($urandom)};
    do_reset();
    for (int cyc = 1; cyc <= 450; cyc++) begin
      if (cyc > 1) begin
        h = ($urandom_range(0, 7) == 0);
        st = 4'($urandom);
        step(h, st);
      end else begin
        h = 1'b0; st = 4'h0;
      end
      if (h) held = 1'b1;
      if (h) begin
        n_checks++; if ({im_re, instr_valid} !== 2'b00) begin n_errors++; $display("FAIL rnd_hold c%0d: got re=%b v=%b", cyc, im_re, instr_valid); end
      end
      if (instr_valid === 1'b1) begin
        exp_t = ref_take(mem[model_pc][14:8], st);
        n_checks++; if ({pc, opcode, literal} !== {model_pc, mem[model_pc]}) begin n_errors++; $display("FAIL rnd_instr c%0d: got pc=%h op=%h lit=%h want pc=%h word=%h", cyc, pc, opcode, literal, model_pc, mem[model_pc]); end
        n_checks++; if (jump_taken !== exp_t) begin n_errors++; $display("FAIL rnd_taken c%0d: got %b want %b", cyc, jump_taken, exp_t); end
        if (!held) begin
          n_checks++; if (cyc - last != 3) begin n_errors++; $display("FAIL rnd_gap c%0d: got %0d want 3", cyc, cyc - last); end
        end
        model_pc = exp_t ? mem[model_pc][7:0] : model_pc + 8'h01;
        last = cyc;
        held = 1'b0;
      end else begin
        n_checks++; if ({opcode, literal, jump_taken} !== {NOP, 8'h00, 1'b0}) begin n_errors++; $display("FAIL rnd_idle c%0d: got op=%h lit=%h t=%b", cyc, opcode, literal, jump_taken); end
      end
      if (cyc - last > 60) begin
        n_checks++; n_errors++;
        $display("FAIL rnd_timeout c%0d: no instr_valid for %0d cycles", cyc, cyc - last);
        break;
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_linear();
    test_jeq();
    test_cond_sweep();
    test_wrap();
    test_hold_wait();
    test_hold_exec();
    test_halt_reset();
    test_random_program();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
